// File: rtl/mdu_if.sv
// Execute-stage command and HI/LO result bundle between the pipeline and the MDU sequencer.
// The command has no ready signal: decode must hold MDU instructions while stall is high.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        md_use;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  modport master (output start, op, rs_data, rt_data, md_use,
                  input  hi, lo, busy, stall);
  modport slave  (input  start, op, rs_data, rt_data, md_use,
                  output hi, lo, busy, stall);
endinterface

// File: rtl/mdu_controller.sv
// HI/LO sequencer: the result is computed at acceptance, held in pending registers,
// and committed after a fixed latency while busy/stall hold off dependent instructions.
module mdu_controller #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus,
  output logic dbg_state
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] phi, phi_n, plo, plo_n;
  logic [31:0] hi_q, hi_n, lo_q, lo_n;

  logic [31:0] a, b, b_safe;
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, uq, ur, sq, sr, dq, dr;
  logic        start_mul_div;

  assign a = bus.rs_data;
  assign b = bus.rt_data;

  // Divide by 1 when the divisor is zero so the divider never sees x; the result is discarded.
  assign b_safe = (b == 32'd0) ? 32'd1 : b;

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    abs_a  = a[31] ? (32'd0 - a) : a;
    abs_b  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
    // Magnitude divide; 0x80000000/-1 falls out as quotient 0x80000000, remainder 0.
    uq     = abs_a / abs_b;
    ur     = abs_a % abs_b;
    sq     = (a[31] ^ b_safe[31]) ? (32'd0 - uq) : uq;
    sr     = a[31] ? (32'd0 - ur) : ur;
    dq     = a / b_safe;
    dr     = a % b_safe;
  end

  assign start_mul_div = bus.start & (state == IDLE) & (bus.op <= 3'd3);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    phi_n   = phi;
    plo_n   = plo;
    hi_n    = hi_q;
    lo_n    = lo_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'd0: begin
              {phi_n, plo_n} = prod_s;
              cnt_n = MUL_LOAD;
              state_n = BUSY;
            end
            3'd1: begin
              {phi_n, plo_n} = prod_u;
              cnt_n = MUL_LOAD;
              state_n = BUSY;
            end
            3'd2, 3'd3: begin
              if (b == 32'd0) begin
                phi_n = hi_q;
                plo_n = lo_q;
              end else if (bus.op == 3'd2) begin
                phi_n = sr;
                plo_n = sq;
              end else begin
                phi_n = dr;
                plo_n = dq;
              end
              cnt_n = DIV_LOAD;
              state_n = BUSY;
            end
            3'd4: hi_n = a;
            3'd5: lo_n = a;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          hi_n    = phi;
          lo_n    = plo;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      phi   <= 32'd0;
      plo   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      phi   <= phi_n;
      plo   <= plo_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = (state == BUSY);
  assign bus.stall = bus.md_use & ((state == BUSY) | start_mul_div);
  assign dbg_state = (state == BUSY);
endmodule

// File: tb/tb_mdu_controller.sv
// Bench for mdu_controller: default-latency DUT plus a single-cycle-latency DUT on the same inputs,
// both checked against a 64-bit arithmetic model of HI/LO.
module tb_mdu_controller;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic clk;
  logic reset;
  logic dbg0, dbg1;

  mdu_if bus ();
  mdu_if bus1 ();

  assign bus1.start   = bus.start;
  assign bus1.op      = bus.op;
  assign bus1.rs_data = bus.rs_data;
  assign bus1.rt_data = bus.rt_data;
  assign bus1.md_use  = bus.md_use;

  mdu_controller #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg0));

  mdu_controller #(.MUL_CYCLES(1), .DIV_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .dbg_state(dbg1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [31:0] m1_hi = 0, m1_lo = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Expected {hi,lo} after a mul/div command, from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] ch,
                                        input logic [31:0] cl);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 0) return {ch, cl};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {ch, cl};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic md, input bit inject_mtlo);
    int n;
    logic [63:0] e1, e;
    logic [31:0] inj;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b; bus.md_use = md;
    #1;
    chk("stall_start", bus.stall, md && (op <= 3));
    if (op <= 3) begin
      exp_q.push_back(model(op, a, b, m_hi, m_lo));
      e1 = model(op, a, b, m1_hi, m1_lo);
      n = (op <= 1) ? MUL_N : DIV_N;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (op <= 3) begin
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        chk("busy_hold", {dbg0, bus.busy}, 2'b11);
        chk("hilo_hold", {bus.hi, bus.lo}, {m_hi, m_lo});
        chk("stall_busy", bus.stall, md);
        if (i == 0) chk("n1_busy", bus1.busy, 1'b1);
        if (i == 1) begin
          chk("n1_commit", {bus1.hi, bus1.lo}, e1);
          chk("n1_idle", bus1.busy, 1'b0);
          {m1_hi, m1_lo} = e1;
        end
        if (inject_mtlo && i == 2) begin
          inj = $urandom;
          bus.start = 1'b1; bus.op = 3'd5; bus.rs_data = inj;
          @(posedge clk); #1;
          bus.start = 1'b0;
          m1_lo = inj;
        end
      end
      @(negedge clk);
      e = exp_q.pop_front();
      chk("commit_busy", bus.busy, 1'b0);
      chk("commit_stall", bus.stall, 1'b0);
      chk("commit_hilo", {bus.hi, bus.lo}, e);
      {m_hi, m_lo} = e;
    end else begin
      if (op == 3'd4) begin m_hi = a; m1_hi = a; end
      if (op == 3'd5) begin m_lo = a; m1_lo = a; end
      @(negedge clk);
      chk("mt_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
      chk("mt_busy", {bus.busy, bus.stall}, 2'b00);
      chk("mt_n1_hilo", {bus1.hi, bus1.lo}, {m1_hi, m1_lo});
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    reset = 1'b0;
    bus.start = 1'b0; bus.op = 3'd0; bus.rs_data = 0; bus.rt_data = 0; bus.md_use = 1'b0;
    #12;
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_busy", {dbg0, bus.busy, bus.stall}, 3'b000);
    @(negedge clk);
    reset = 1'b1;

    run_op(3'd0, 32'hFFFFFFFF, 32'h2, 1'b1, 1'b0);
    chk("mult_dir", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFE);
    run_op(3'd1, 32'hFFFFFFFF, 32'h2, 1'b0, 1'b0);
    chk("multu_dir", {bus.hi, bus.lo}, 64'h00000001_FFFFFFFE);
    run_op(3'd2, 32'hFFFFFFF9, 32'h2, 1'b1, 1'b0);
    chk("div_dir", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(3'd3, 32'h7, 32'h0, 1'b1, 1'b0);
    chk("divu_zero", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    chk("div_ovf", {bus.hi, bus.lo}, 64'h00000000_80000000);
    run_op(3'd4, 32'h12345678, 32'h0, 1'b1, 1'b0);
    chk("mthi_dir", bus.hi, 32'h12345678);
    run_op(3'd0, 32'd1000, 32'hFFFFFFFD, 1'b1, 1'b1);
    chk("mtlo_ignored", bus.lo, 32'hFFFFF448);
    run_op(3'd6, 32'hDEADBEEF, 32'h1, 1'b1, 1'b0);

    for (int k = 0; k < 24; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      run_op(op, a, b, 1'($urandom_range(0, 1)), 1'b0);
    end

    run_op(3'd5, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd2; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_mid_busy", {dbg0, bus.busy}, 2'b00);
    chk("rst_mid_n1", {bus1.hi, bus1.lo, bus1.busy}, 65'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_no_commit", {bus.hi, bus.lo}, 64'd0);
    chk("rst_idle", bus.busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mdu_controller.md
# mdu_controller

Sequencer for the HI/LO register pair of the pipelined MIPS core. Accepts multiply, divide and move-to-HI/LO commands from the execute stage and holds HI/LO in internal enable-gated registers. Models fixed multi-cycle latency with a busy counter and raises a stall request so decode holds any MDU-dependent instruction until the result is committed.

## Interface
Parameters:
- MUL_CYCLES, default 5: cycles from accepted MULT/MULTU to HI/LO commit; legal range 1..15.
- DIV_CYCLES, default 10: cycles from accepted DIV/DIVU to HI/LO commit; legal range 1..15.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately when low.
- start  in  1  command valid from EX stage, sampled on posedge.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (no-op).
- rs_data  in  32  operand A (dividend / multiplicand / MT source).
- rt_data  in  32  operand B (divisor / multiplier).
- md_use  in  1  instruction in decode uses the MDU (mult/div/mfhi/mflo/mthi/mtlo).
- hi  out  32  committed HI value.
- lo  out  32  committed LO value.
- busy  out  1  operation in flight.
- stall  out  1  decode stall request, combinational: md_use & (busy | start_mul_div).

## Operation
- States: IDLE, BUSY. State register, 4-bit down counter, pending_hi/pending_lo (32 each), hi/lo registers.
- IDLE, start=1, op in {0..3}: compute result from rs_data/rt_data in the same cycle, latch into pending_hi/pending_lo, load counter with MUL_CYCLES-1 (op 0/1) or DIV_CYCLES-1 (op 2/3), go BUSY.
- IDLE, start=1, op 4: hi <= rs_data at that edge; op 5: lo <= rs_data. No busy. Op 6/7: ignored.
- BUSY: counter decrements each edge; at the edge where counter==0, hi <= pending_hi, lo <= pending_lo, go IDLE.
- start while BUSY: ignored entirely (pipeline guarantees this does not happen via stall; the block must not corrupt state if it does).
- MULT: {hi,lo} = signed 32x32 -> 64 product. MULTU: unsigned 64-bit product.
- DIV: lo = signed quotient truncated toward zero, hi = remainder with sign of dividend. DIVU: unsigned quotient/remainder.
- Divide by zero (rt_data==0): full DIV_CYCLES latency, pending = current hi/lo, so HI/LO unchanged at commit.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- start_mul_div = start & ~busy & (op<=3) (internal).

## Timing
- Reset (reset=0): hi=0, lo=0, busy=0, state IDLE, counter=0, pending=0, asynchronously; holds while low. Reset mid-operation aborts the operation, no commit.
- Command accepted at edge k: busy=1 from after edge k through edge k+N (N = MUL_CYCLES or DIV_CYCLES); hi/lo show the new result and busy=0 after edge k+N. Back-to-back: new start accepted at edge k+N+1 at earliest... no: start at edge k+N is ignored (busy still 1 before that edge); next acceptance at the first edge with busy=0.
- N=1: result committed at edge k+1, busy high exactly one cycle.
- MTHI/MTLO: hi/lo visible one cycle after the accepting edge, zero-latency stall.
- stall is asserted in the cycle start_mul_div is high and for all BUSY cycles when md_use=1; deasserts the cycle after commit.
- hi/lo outputs change only at commit, MT edges, or reset; never glitch from pending.

## Test plan
- Reset: drive reset=0 mid-DIV (cycle 4 of 10) -> hi=lo=0, busy=0 immediately; no commit after release.
- MULT rs=0xFFFFFFFF, rt=0x00000002, MUL_CYCLES=5 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi/lo unchanged, busy still 10 cycles.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678 while IDLE -> hi=0x12345678 next cycle, busy stays 0; MTLO issued while BUSY -> ignored, lo equals operation result after commit.
- Stall: md_use=1 throughout a MULT -> stall high in the start cycle and all 5 busy cycles, low the cycle after commit; md_use=0 -> stall never asserted.
